// File: rtl/slice_serial_adder_ctrl.sv
// slice_serial_adder_ctrl: serial wide adder that reuses one SLICE-bit ripple adder
// over NSLICE cycles, with the LSB slice first and a registered carry between slices.
// Operands come in and results go out through valid/ready handshakes.
// Optional feature macro: SLICE_ADDER_APPROX_EN (drops the carry-out of the low
// APPROX_SLICES slices for an error-tolerant, shorter-carry-chain add).

// Combinational ripple-carry adder; the sum wraps modulo 2^W.
module ripple_carry_adder #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic carry;

  // Bit-serial carry ripple from LSB to MSB.
  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < int'(W); i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

module slice_serial_adder_ctrl #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SLICE         = 4,
  parameter int unsigned APPROX_SLICES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  // WIDTH must be an integer multiple of SLICE.
  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

`ifdef SLICE_ADDER_APPROX_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;

  logic [SLICE:0]   slice_sum;
  logic             slice_cout;
  logic             approx_slice;
  logic             carry_next;
  logic [WIDTH-1:0] result_next;

  // The single shared slice adder; operands are zero-extended so bit SLICE is the carry-out.
  ripple_carry_adder #(
    .W (SLICE + 1)
  ) u_slice_adder (
    .a   ({1'b0, opa[SLICE-1:0]}),
    .b   ({1'b0, opb[SLICE-1:0]}),
    .cin (carry_q),
    .sum (slice_sum)
  );

  assign slice_cout = slice_sum[SLICE];

  // In approximate mode, the low slices do not forward their carry.
  assign approx_slice = APPROX_EN && (32'(cnt) < APPROX_SLICES);
  assign carry_next   = approx_slice ? 1'b0 : slice_cout;

  // Each slice sum enters the result register at the MSB end and shifts toward the LSB.
  generate
    if (NSLICE == 1) begin : g_single
      assign result_next = slice_sum[SLICE-1:0];
    end else begin : g_multi
      assign result_next = {slice_sum[SLICE-1:0], result_o[WIDTH-1:SLICE]};
    end
  endgenerate

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      carry_o     <= 1'b0;
      cnt         <= '0;
      carry_q     <= 1'b0;
      opa         <= '0;
      opb         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            opa        <= add1_i;
            opb        <= add2_i;
            carry_q    <= carry_i;
            cnt        <= '0;
            in_ready_o <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          result_o <= result_next;
          opa      <= opa >> SLICE;
          opb      <= opb >> SLICE;
          carry_q  <= carry_next;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            carry_o     <= carry_next;
            out_valid_o <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_serial_adder_ctrl.sv
// Directed testbench for slice_serial_adder_ctrl (WIDTH=16, SLICE=4, APPROX_SLICES=1).
// The expected values follow SLICE_ADDER_APPROX_EN when that macro is defined.
module tb_slice_serial_adder_ctrl;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned SLICE  = 4;
  localparam int unsigned NSLICE = WIDTH / SLICE;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] add1;
  logic [WIDTH-1:0] add2;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  slice_serial_adder_ctrl #(
    .WIDTH         (WIDTH),
    .SLICE         (SLICE),
    .APPROX_SLICES (1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .add1_i      (add1),
    .add2_i      (add2),
    .carry_i     (carry_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .carry_o     (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Runs one complete add. It checks the latency, the result, the carry and the handshake.
  task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic [WIDTH-1:0] exp_r,
                        input logic exp_c, input string name);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    add1 = a; add2 = b; carry_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s in_ready during RUN: got %b want 0", name, in_ready);
    end
    for (int k = 1; k <= int'(NSLICE); k++) begin
      @(posedge clk); #1;
      if (k == int'(NSLICE) - 1) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s early out_valid at edge E+%0d: got %b want 0", name, k, out_valid);
        end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid at edge E+%0d: got %b want 1", name, NSLICE, out_valid);
    end
    n_checks++;
    if (result !== exp_r || carry_out !== exp_c) begin
      n_fail++;
      $display("FAIL %s result/carry: got %h/%b want %h/%b", name, result, carry_out, exp_r, exp_c);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s return to idle: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    add1 = '0; add2 = '0; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h c=%b want 1/0/0000/0",
               in_ready, out_valid, result, carry_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "add_1234_4321");
`ifdef SLICE_ADDER_APPROX_EN
    do_add(16'hFFFF, 16'h0001, 1'b0, 16'hFFF0, 1'b0, "add_ffff_0001");
    do_add(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFEF, 1'b1, "add_ffff_ffff_c1");
`else
    do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "add_ffff_0001");
    do_add(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "add_ffff_ffff_c1");
`endif
    do_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "add_8000_8000");
  endtask

  task automatic test_hold();
    int waited;
    add1 = 16'h0102; add2 = 16'h0304; carry_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_reach_done: got out_valid=%b want 1", out_valid);
    end
    // Holds out_ready low and sends an add that the DUT must ignore.
    add1 = 16'hAAAA; add2 = 16'h5555; carry_in = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h0407 || carry_out !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got vld=%b rdy=%b res=%h c=%b want 1/0/0407/0",
                 k, out_valid, in_ready, result, carry_out);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ignored_input: got rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    add1 = 16'h1234; add2 = 16'h4321; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got rdy=%b vld=%b res=%h c=%b want 1/0/0000/0",
               in_ready, out_valid, result, carry_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_add(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "add_after_reset");
  endtask

  task automatic test_approx();
`ifdef SLICE_ADDER_APPROX_EN
    do_add(16'h000F, 16'h0001, 1'b0, 16'h0000, 1'b0, "approx_000f_0001");
`else
    do_add(16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, "exact_000f_0001");
`endif
  endtask

  task automatic test_back_to_back();
    int waited;
    int first_cyc;
    out_ready = 1'b1;
    add1 = 16'h0102; add2 = 16'h0304; carry_in = 1'b0; in_valid = 1'b1;
    waited = 0;
    @(posedge clk); #1;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    first_cyc = cyc;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 16'h0406 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got vld=%b res=%h c=%b want 1/0406/0", out_valid, result, carry_out);
    end
    add1 = 16'h7000; add2 = 16'h9000;
    waited = 0;
    @(posedge clk); #1;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 16'h0000 || carry_out !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got vld=%b res=%h c=%b want 1/0000/1", out_valid, result, carry_out);
    end
    n_checks++;
    if (cyc - first_cyc !== int'(NSLICE) + 2) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d cycles want %0d", cyc - first_cyc, NSLICE + 2);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_approx();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
